// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes,
// datapath select codes, trap causes, FSM states and the decoded bundle.
package riscv_ctrl_pkg;

  localparam logic [4:0] OPC_R      = 5'b01100;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;

  localparam logic [2:0] IMM_I     = 3'd0;
  localparam logic [2:0] IMM_SHIFT = 3'd1;
  localparam logic [2:0] IMM_S     = 3'd2;
  localparam logic [2:0] IMM_B     = 3'd3;
  localparam logic [2:0] IMM_J     = 3'd4;
  localparam logic [2:0] IMM_U     = 3'd5;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_IMM   = 2'd1;
  localparam logic [1:0] ALU_REG   = 2'd2;
  localparam logic [1:0] ALU_PASSB = 2'd3;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_REL   = 2'd1;
  localparam logic [1:0] PC_RS1   = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  // Instruction class steers the EXEC/MEM/WB sequencing and the pc_src choice
  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR
  } iclass_t;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc;
    logic       regsrc;
    logic       pc_rs1_sel;
    logic       branch;
    logic [2:0] immsel;
    logic       memread;
    logic       memwrite;
    iclass_t    iclass;
  } ctrl_t;

endpackage

// File: rtl/instr_decode.sv
// Purely combinational opcode/f3 classifier producing the static controls
// and an illegal-opcode flag.
module instr_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [2:0] f3,
  output ctrl_t      ctrl,
  output logic       illegal
);

  // Start from an all-zero bundle so each opcode only sets what it needs
  always_comb begin
    ctrl    = '0;
    ctrl.iclass = CLS_ALU;
    illegal = 1'b0;
    case (opcode)
      OPC_R: ctrl.aluop = ALU_REG;
      OPC_OPIMM: begin
        ctrl.aluop  = ALU_IMM;
        ctrl.alusrc = 1'b1;
        ctrl.immsel = (f3 == 3'b001 || f3 == 3'b101) ? IMM_SHIFT : IMM_I;
      end
      OPC_LOAD: begin
        ctrl.aluop   = ALU_ADD;
        ctrl.alusrc  = 1'b1;
        ctrl.regsrc  = 1'b1;
        ctrl.memread = 1'b1;
        ctrl.iclass  = CLS_LOAD;
      end
      OPC_STORE: begin
        ctrl.alusrc   = 1'b1;
        ctrl.immsel   = IMM_S;
        ctrl.memwrite = 1'b1;
        ctrl.iclass   = CLS_STORE;
      end
      OPC_BRANCH: begin
        ctrl.immsel = IMM_B;
        ctrl.branch = 1'b1;
        ctrl.iclass = CLS_BRANCH;
      end
      OPC_JAL: begin
        ctrl.aluop  = ALU_PASSB;
        ctrl.immsel = IMM_J;
        ctrl.branch = 1'b1;
        ctrl.iclass = CLS_JAL;
      end
      OPC_JALR: begin
        ctrl.aluop      = ALU_PASSB;
        ctrl.immsel     = IMM_J;
        ctrl.branch     = 1'b1;
        ctrl.pc_rs1_sel = 1'b1;
        ctrl.iclass     = CLS_JALR;
      end
      OPC_LUI: begin
        ctrl.aluop  = ALU_PASSB;
        ctrl.alusrc = 1'b1;
        ctrl.regsrc = 1'b1;
        ctrl.immsel = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl.aluop  = ALU_ADD;
        ctrl.alusrc = 1'b1;
        ctrl.immsel = IMM_U;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with cache handshakes,
// wait timeouts and sticky traps.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int OPC_W    = 5,
  parameter int IMMSEL_W = 3,
  parameter int TO_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [2:0]          f3,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                branch_taken,
  input  logic                trap_clr,
  output logic                imem_req,
  output logic                ir_write,
  output logic                dmem_req,
  output logic                memread,
  output logic                memwrite,
  output logic [1:0]          aluop,
  output logic                alusrc,
  output logic                regsrc,
  output logic                pc_rs1_sel,
  output logic                branch,
  output logic [IMMSEL_W-1:0] immsel,
  output logic                regwrite,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                trap,
  output logic [1:0]          trap_cause
);

  // Waiting at this count means the next wait cycle saturates the counter
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_t          state, state_nxt;
  ctrl_t           dec, ctrl_q;
  logic            illegal;
  logic            active;
  logic [TO_W-1:0] wait_cnt;
  logic [1:0]      cause_q, cause_nxt;
  logic            waiting, expire;

  instr_decode u_decode (
    .opcode  (opcode),
    .f3      (f3),
    .ctrl    (dec),
    .illegal (illegal)
  );

  assign waiting = active && ((state == S_FETCH && !imem_ready) ||
                              (state == S_MEM   && !dmem_ready));
  assign expire  = waiting && (wait_cnt == TO_LAST);

  // State register, decoded-control capture, wait counter and trap cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      active   <= 1'b0;
      ctrl_q   <= '0;
      wait_cnt <= '0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state   <= state_nxt;
      active  <= 1'b1;
      cause_q <= cause_nxt;
      if (state == S_DECODE && !illegal)
        ctrl_q <= dec;
      if (state_nxt != state)
        wait_cnt <= '0;
      else if (waiting)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Next-state logic plus the handshake requests and one-cycle pulses
  always_comb begin
    state_nxt = state;
    cause_nxt = cause_q;
    imem_req  = 1'b0;
    ir_write  = 1'b0;
    dmem_req  = 1'b0;
    regwrite  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_PLUS4;
    case (state)
      S_FETCH: begin
        if (active) begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_write  = 1'b1;
            state_nxt = S_DECODE;
          end else if (expire) begin
            state_nxt = S_TRAP;
            cause_nxt = CAUSE_IMEM_TO;
          end
        end
      end
      S_DECODE: begin
        if (illegal) begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_ILLEGAL;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        case (ctrl_q.iclass)
          CLS_LOAD, CLS_STORE: state_nxt = S_MEM;
          CLS_BRANCH: begin
            pc_write  = 1'b1;
            pc_src    = branch_taken ? PC_REL : PC_PLUS4;
            state_nxt = S_FETCH;
          end
          default: state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          if (ctrl_q.iclass == CLS_STORE) begin
            pc_write  = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end else if (expire) begin
          state_nxt = S_TRAP;
          cause_nxt = CAUSE_DMEM_TO;
        end
      end
      S_WB: begin
        regwrite  = 1'b1;
        pc_write  = 1'b1;
        state_nxt = S_FETCH;
        if (ctrl_q.iclass == CLS_JAL)
          pc_src = PC_REL;
        else if (ctrl_q.iclass == CLS_JALR)
          pc_src = PC_RS1;
      end
      S_TRAP: begin
        if (trap_clr) begin
          state_nxt = S_FETCH;
          cause_nxt = CAUSE_NONE;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  assign memread    = ctrl_q.memread;
  assign memwrite   = ctrl_q.memwrite;
  assign aluop      = ctrl_q.aluop;
  assign alusrc     = ctrl_q.alusrc;
  assign regsrc     = ctrl_q.regsrc;
  assign pc_rs1_sel = ctrl_q.pc_rs1_sel;
  assign branch     = ctrl_q.branch;
  assign immsel     = ctrl_q.immsel;
  assign trap       = (state == S_TRAP);
  assign trap_cause = cause_q;

endmodule
